// File: rtl/ysyx_22050039_pkg.sv
// Shared constants and types for the ysyx_22050039 RV64I-subset core:
// opcodes, ALU function codes and the decoded control bundle.
package ysyx_22050039_pkg;

  localparam int          DEF_XLEN     = 64;
  localparam int          DEF_INST_LEN = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
  localparam int          FUNC_LEN     = 4;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [FUNC_LEN-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_PASS_B
  } alu_func_e;

  typedef struct packed {
    alu_func_e  alu_func;
    logic       src_a_pc;
    logic       src_b_imm;
    logic       reg_wen;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
    logic [2:0] br_func;
    logic       is_ebreak;
    logic       is_illegal;
  } ctrl_t;

endpackage

// File: rtl/ysyx_22050039_exu.sv
// Execute unit: ALU, branch compare, next-PC selection and writeback data.
module ysyx_22050039_exu
  import ysyx_22050039_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  ctrl_t           i_ctrl,
  input  logic            i_pc_wen,
  output logic [XLEN-1:0] o_dnpc,
  output logic [XLEN-1:0] o_wb_data
);

  logic [XLEN-1:0] w_a, w_b, w_alu, w_pc4;
  logic [5:0]      w_shamt;
  logic [31:0]     w_addw, w_subw;
  logic            w_taken;

  assign w_a     = i_ctrl.src_a_pc  ? i_pc  : i_rs1_data;
  assign w_b     = i_ctrl.src_b_imm ? i_imm : i_rs2_data;
  assign w_shamt = w_b[5:0];
  assign w_addw  = w_a[31:0] + w_b[31:0];
  assign w_subw  = w_a[31:0] - w_b[31:0];
  assign w_pc4   = i_pc + XLEN'(4);

  always_comb begin
    w_alu = '0;
    case (i_ctrl.alu_func)
      ALU_ADD:    w_alu = w_a + w_b;
      ALU_SUB:    w_alu = w_a - w_b;
      ALU_SLL:    w_alu = w_a << w_shamt;
      ALU_SLT:    w_alu = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      ALU_SLTU:   w_alu = {{(XLEN-1){1'b0}}, w_a < w_b};
      ALU_XOR:    w_alu = w_a ^ w_b;
      ALU_SRL:    w_alu = w_a >> w_shamt;
      ALU_SRA:    w_alu = $unsigned($signed(w_a) >>> w_shamt);
      ALU_OR:     w_alu = w_a | w_b;
      ALU_AND:    w_alu = w_a & w_b;
      ALU_ADDW:   w_alu = {{(XLEN-32){w_addw[31]}}, w_addw};
      ALU_SUBW:   w_alu = {{(XLEN-32){w_subw[31]}}, w_subw};
      ALU_PASS_B: w_alu = w_b;
      default:    w_alu = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (i_ctrl.br_func)
      3'b000:  w_taken = (i_rs1_data == i_rs2_data);
      3'b001:  w_taken = (i_rs1_data != i_rs2_data);
      3'b100:  w_taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
      3'b101:  w_taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
      3'b110:  w_taken = (i_rs1_data <  i_rs2_data);
      3'b111:  w_taken = (i_rs1_data >= i_rs2_data);
      default: w_taken = 1'b0;
    endcase
  end

  // A core that is halted, or about to halt, reports its own PC as next PC
  always_comb begin
    o_dnpc = w_pc4;
    if (!i_pc_wen)                       o_dnpc = i_pc;
    else if (i_ctrl.is_jal)              o_dnpc = i_pc + i_imm;
    else if (i_ctrl.is_jalr)             o_dnpc = w_alu & {{(XLEN-1){1'b1}}, 1'b0};
    else if (i_ctrl.is_branch && w_taken) o_dnpc = i_pc + i_imm;
  end

  assign o_wb_data = (i_ctrl.is_jal || i_ctrl.is_jalr) ? w_pc4 : w_alu;

endmodule

// File: rtl/ysyx_22050039_idu.sv
// Decode unit: instruction decode, immediate generation, register file
// and the sticky halt/trap state that freezes the core.
module ysyx_22050039_idu
  import ysyx_22050039_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int INST_LEN = DEF_INST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INST_LEN-1:0] i_inst,
  input  logic [XLEN-1:0]     i_wb_data,
  output ctrl_t               o_ctrl,
  output logic [XLEN-1:0]     o_imm,
  output logic [XLEN-1:0]     o_rs1_data,
  output logic [XLEN-1:0]     o_rs2_data,
  output logic [XLEN-1:0]     o_a0,
  output logic                o_pc_wen,
  output logic                o_halt,
  output logic                o_trap
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic            w_halt_cond;
  logic            r_halt;
  logic            r_trap;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_funct7 = i_inst[31:25];

  assign w_imm_i = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
  assign w_imm_b = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7],
                    i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                    i_inst[20], i_inst[30:21], 1'b0};

  always_comb begin
    w_ctrl          = '0;
    w_ctrl.alu_func = ALU_ADD;
    w_imm           = '0;
    case (w_opcode)
      OPC_LUI: begin
        w_ctrl.alu_func  = ALU_PASS_B;
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.reg_wen   = 1'b1;
        w_imm            = w_imm_u;
      end
      OPC_AUIPC: begin
        w_ctrl.src_a_pc  = 1'b1;
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.reg_wen   = 1'b1;
        w_imm            = w_imm_u;
      end
      OPC_JAL: begin
        w_ctrl.is_jal  = 1'b1;
        w_ctrl.reg_wen = 1'b1;
        w_imm          = w_imm_j;
      end
      OPC_JALR: begin
        w_ctrl.is_jalr    = 1'b1;
        w_ctrl.src_b_imm  = 1'b1;
        w_ctrl.reg_wen    = 1'b1;
        w_ctrl.is_illegal = (w_funct3 != 3'b000);
        w_imm             = w_imm_i;
      end
      OPC_BRANCH: begin
        w_ctrl.is_branch  = 1'b1;
        w_ctrl.br_func    = w_funct3;
        w_ctrl.is_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        w_imm             = w_imm_b;
      end
      OPC_OP_IMM: begin
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.reg_wen   = 1'b1;
        w_imm            = w_imm_i;
        case (w_funct3)
          3'b000: w_ctrl.alu_func = ALU_ADD;
          3'b010: w_ctrl.alu_func = ALU_SLT;
          3'b011: w_ctrl.alu_func = ALU_SLTU;
          3'b100: w_ctrl.alu_func = ALU_XOR;
          3'b110: w_ctrl.alu_func = ALU_OR;
          3'b111: w_ctrl.alu_func = ALU_AND;
          3'b001: begin
            w_ctrl.alu_func   = ALU_SLL;
            w_ctrl.is_illegal = (i_inst[31:26] != 6'b000000);
          end
          default: begin
            // inst[30] selects arithmetic shift; the other upper bits must be 0
            w_ctrl.alu_func   = i_inst[30] ? ALU_SRA : ALU_SRL;
            w_ctrl.is_illegal = ({i_inst[31], i_inst[29:26]} != 5'b00000);
          end
        endcase
      end
      OPC_OP: begin
        w_ctrl.reg_wen = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b000:  w_ctrl.alu_func = ALU_ADD;
            3'b001:  w_ctrl.alu_func = ALU_SLL;
            3'b010:  w_ctrl.alu_func = ALU_SLT;
            3'b011:  w_ctrl.alu_func = ALU_SLTU;
            3'b100:  w_ctrl.alu_func = ALU_XOR;
            3'b101:  w_ctrl.alu_func = ALU_SRL;
            3'b110:  w_ctrl.alu_func = ALU_OR;
            default: w_ctrl.alu_func = ALU_AND;
          endcase
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_ctrl.alu_func = ALU_SUB;
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
          w_ctrl.alu_func = ALU_SRA;
        end else begin
          w_ctrl.is_illegal = 1'b1;
        end
      end
      OPC_OP_IMM_32: begin
        w_ctrl.alu_func   = ALU_ADDW;
        w_ctrl.src_b_imm  = 1'b1;
        w_ctrl.reg_wen    = 1'b1;
        w_ctrl.is_illegal = (w_funct3 != 3'b000);
        w_imm             = w_imm_i;
      end
      OPC_OP_32: begin
        w_ctrl.reg_wen = 1'b1;
        if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000)      w_ctrl.alu_func = ALU_ADDW;
        else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) w_ctrl.alu_func = ALU_SUBW;
        else                                                   w_ctrl.is_illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (i_inst == INST_EBREAK) w_ctrl.is_ebreak  = 1'b1;
        else                       w_ctrl.is_illegal = 1'b1;
      end
      default: w_ctrl.is_illegal = 1'b1;
    endcase
    if (w_ctrl.is_illegal) w_ctrl.reg_wen = 1'b0;
  end

  assign w_halt_cond = w_ctrl.is_ebreak || w_ctrl.is_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt <= 1'b0;
      r_trap <= 1'b0;
    end else if (!r_halt && w_halt_cond) begin
      r_halt <= 1'b1;
      r_trap <= w_ctrl.is_illegal;
    end
  end

  ysyx_22050039_regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_raddr1 (i_inst[19:15]),
    .i_raddr2 (i_inst[24:20]),
    .i_wen    (w_ctrl.reg_wen && !r_halt),
    .i_waddr  (i_inst[11:7]),
    .i_wdata  (i_wb_data),
    .o_rdata1 (o_rs1_data),
    .o_rdata2 (o_rs2_data),
    .o_a0     (o_a0)
  );

  assign o_ctrl   = w_ctrl;
  assign o_imm    = w_imm;
  assign o_pc_wen = !r_halt && !w_halt_cond;
  assign o_halt   = r_halt;
  assign o_trap   = r_trap;

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: holds the PC and advances it when the decoder
// allows the current instruction to retire.
module ysyx_22050039_ifu
  import ysyx_22050039_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pc_wen,
  input  logic [XLEN-1:0] i_dnpc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst)           r_pc <= RESET_PC;
    else if (i_pc_wen) r_pc <= i_dnpc;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22050039_regfile.sv
// 32 x XLEN integer register file: two combinational read ports, one
// write port, x0 hardwired to zero.
module ysyx_22050039_regfile
  import ysyx_22050039_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  input  logic            i_wen,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2,
  output logic [XLEN-1:0] o_a0
);

  logic [XLEN-1:0] r_regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_wen && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];
  assign o_a0     = r_regs[10];

endmodule

// File: rtl/ysyx_22050039_core.sv
// Single-cycle RV64I-subset core: IFU (PC), IDU (decode + regfile + halt)
// and EXU (ALU + next PC); one instruction retires per clock.
module ysyx_22050039_core
  import ysyx_22050039_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter int              INST_LEN = DEF_INST_LEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  output logic [XLEN-1:0]     inst_addr,
  input  logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     dnpc,
  output logic                halt,
  output logic                trap,
  output logic [XLEN-1:0]     a0
);

  logic [XLEN-1:0] w_pc, w_dnpc, w_wb_data, w_imm, w_rs1_data, w_rs2_data;
  logic            w_pc_wen;
  ctrl_t           w_ctrl;

  ysyx_22050039_ifu #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_ifu (
    .clk      (clk),
    .rst      (rst),
    .i_pc_wen (w_pc_wen),
    .i_dnpc   (w_dnpc),
    .o_pc     (w_pc)
  );

  ysyx_22050039_idu #(.XLEN(XLEN), .INST_LEN(INST_LEN)) u_idu (
    .clk        (clk),
    .rst        (rst),
    .i_inst     (inst),
    .i_wb_data  (w_wb_data),
    .o_ctrl     (w_ctrl),
    .o_imm      (w_imm),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .o_a0       (a0),
    .o_pc_wen   (w_pc_wen),
    .o_halt     (halt),
    .o_trap     (trap)
  );

  ysyx_22050039_exu #(.XLEN(XLEN)) u_exu (
    .i_pc       (w_pc),
    .i_rs1_data (w_rs1_data),
    .i_rs2_data (w_rs2_data),
    .i_imm      (w_imm),
    .i_ctrl     (w_ctrl),
    .i_pc_wen   (w_pc_wen),
    .o_dnpc     (w_dnpc),
    .o_wb_data  (w_wb_data)
  );

  assign inst_addr = w_pc;
  assign pc        = w_pc;
  assign dnpc      = w_dnpc;

endmodule

// File: tb/tb_ysyx_22050039_core.sv
// Bench for ysyx_22050039_core: directed and random instructions checked
// against an architectural model that works from operation + operands.
module tb_ysyx_22050039_core;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h0;
  logic [63:0] inst_addr, pc, dnpc, a0;
  logic        halt, trap;

  always #5 clk = ~clk;

  ysyx_22050039_core dut (
    .clk       (clk),
    .rst       (rst),
    .inst_addr (inst_addr),
    .inst      (inst),
    .pc        (pc),
    .dnpc      (dnpc),
    .halt      (halt),
    .trap      (trap),
    .a0        (a0)
  );

  typedef enum int {
    T_LUI, T_AUIPC, T_JAL, T_JALR, T_BEQ, T_BNE, T_BLT, T_BGE, T_BLTU, T_BGEU,
    T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI, T_SLLI, T_SRLI, T_SRAI,
    T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU, T_XOR, T_SRL, T_SRA, T_OR, T_AND,
    T_ADDIW, T_ADDW, T_SUBW, T_EBREAK, T_ILL
  } op_e;

  // architectural model state and scoreboard
  logic [63:0] m_x [32];
  logic [63:0] m_pc;
  logic        m_halt, m_trap;
  logic [63:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // driver side: build the machine word for an operation
  function automatic logic [31:0] encode(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [63:0] imm);
    case (op)
      T_LUI:    return {imm[19:0], rd, 7'b0110111};
      T_AUIPC:  return {imm[19:0], rd, 7'b0010111};
      T_JAL:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      T_JALR:   return enc_i(imm[11:0], rs1, 3'd0, rd, 7'b1100111);
      T_BEQ:    return enc_b(imm[12:0], rs2, rs1, 3'd0);
      T_BNE:    return enc_b(imm[12:0], rs2, rs1, 3'd1);
      T_BLT:    return enc_b(imm[12:0], rs2, rs1, 3'd4);
      T_BGE:    return enc_b(imm[12:0], rs2, rs1, 3'd5);
      T_BLTU:   return enc_b(imm[12:0], rs2, rs1, 3'd6);
      T_BGEU:   return enc_b(imm[12:0], rs2, rs1, 3'd7);
      T_ADDI:   return enc_i(imm[11:0], rs1, 3'd0, rd, 7'b0010011);
      T_SLTI:   return enc_i(imm[11:0], rs1, 3'd2, rd, 7'b0010011);
      T_SLTIU:  return enc_i(imm[11:0], rs1, 3'd3, rd, 7'b0010011);
      T_XORI:   return enc_i(imm[11:0], rs1, 3'd4, rd, 7'b0010011);
      T_ORI:    return enc_i(imm[11:0], rs1, 3'd6, rd, 7'b0010011);
      T_ANDI:   return enc_i(imm[11:0], rs1, 3'd7, rd, 7'b0010011);
      T_SLLI:   return enc_i({6'b000000, imm[5:0]}, rs1, 3'd1, rd, 7'b0010011);
      T_SRLI:   return enc_i({6'b000000, imm[5:0]}, rs1, 3'd5, rd, 7'b0010011);
      T_SRAI:   return enc_i({6'b010000, imm[5:0]}, rs1, 3'd5, rd, 7'b0010011);
      T_ADD:    return enc_r(7'h00, rs2, rs1, 3'd0, rd, 7'b0110011);
      T_SUB:    return enc_r(7'h20, rs2, rs1, 3'd0, rd, 7'b0110011);
      T_SLL:    return enc_r(7'h00, rs2, rs1, 3'd1, rd, 7'b0110011);
      T_SLT:    return enc_r(7'h00, rs2, rs1, 3'd2, rd, 7'b0110011);
      T_SLTU:   return enc_r(7'h00, rs2, rs1, 3'd3, rd, 7'b0110011);
      T_XOR:    return enc_r(7'h00, rs2, rs1, 3'd4, rd, 7'b0110011);
      T_SRL:    return enc_r(7'h00, rs2, rs1, 3'd5, rd, 7'b0110011);
      T_SRA:    return enc_r(7'h20, rs2, rs1, 3'd5, rd, 7'b0110011);
      T_OR:     return enc_r(7'h00, rs2, rs1, 3'd6, rd, 7'b0110011);
      T_AND:    return enc_r(7'h00, rs2, rs1, 3'd7, rd, 7'b0110011);
      T_ADDIW:  return enc_i(imm[11:0], rs1, 3'd0, rd, 7'b0011011);
      T_ADDW:   return enc_r(7'h00, rs2, rs1, 3'd0, rd, 7'b0111011);
      T_SUBW:   return enc_r(7'h20, rs2, rs1, 3'd0, rd, 7'b0111011);
      T_EBREAK: return 32'h0010_0073;
      default:  return imm[31:0];
    endcase
  endfunction

  // reference model: architectural effect of one operation
  task automatic model_exec(input op_e op, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [63:0] imm, output logic [63:0] npc,
                            output logic [63:0] res, output logic wr,
                            output logic hc, output logic ill);
    logic [63:0] a, b;
    a = m_x[rs1];
    b = m_x[rs2];
    npc = m_pc + 64'd4;
    res = 64'd0;
    wr = 1'b1;
    hc = 1'b0;
    ill = 1'b0;
    case (op)
      T_LUI:    res = sx32({imm[19:0], 12'h000});
      T_AUIPC:  res = m_pc + sx32({imm[19:0], 12'h000});
      T_JAL:    begin res = m_pc + 64'd4; npc = m_pc + imm; end
      T_JALR:   begin res = m_pc + 64'd4; npc = (a + imm) & ~64'd1; end
      T_BEQ:    begin wr = 1'b0; if (a == b) npc = m_pc + imm; end
      T_BNE:    begin wr = 1'b0; if (a != b) npc = m_pc + imm; end
      T_BLT:    begin wr = 1'b0; if ($signed(a) <  $signed(b)) npc = m_pc + imm; end
      T_BGE:    begin wr = 1'b0; if ($signed(a) >= $signed(b)) npc = m_pc + imm; end
      T_BLTU:   begin wr = 1'b0; if (a <  b) npc = m_pc + imm; end
      T_BGEU:   begin wr = 1'b0; if (a >= b) npc = m_pc + imm; end
      T_ADDI:   res = a + imm;
      T_SLTI:   res = ($signed(a) < $signed(imm)) ? 64'd1 : 64'd0;
      T_SLTIU:  res = (a < imm) ? 64'd1 : 64'd0;
      T_XORI:   res = a ^ imm;
      T_ORI:    res = a | imm;
      T_ANDI:   res = a & imm;
      T_SLLI:   res = a << imm[5:0];
      T_SRLI:   res = a >> imm[5:0];
      T_SRAI:   res = $signed(a) >>> imm[5:0];
      T_ADD:    res = a + b;
      T_SUB:    res = a - b;
      T_SLL:    res = a << b[5:0];
      T_SLT:    res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      T_SLTU:   res = (a < b) ? 64'd1 : 64'd0;
      T_XOR:    res = a ^ b;
      T_SRL:    res = a >> b[5:0];
      T_SRA:    res = $signed(a) >>> b[5:0];
      T_OR:     res = a | b;
      T_AND:    res = a & b;
      T_ADDIW:  res = sx32(a[31:0] + imm[31:0]);
      T_ADDW:   res = sx32(a[31:0] + b[31:0]);
      T_SUBW:   res = sx32(a[31:0] - b[31:0]);
      T_EBREAK: begin wr = 1'b0; hc = 1'b1; end
      default:  begin wr = 1'b0; hc = 1'b1; ill = 1'b1; end
    endcase
  endtask

  // one clock: present instruction, check combinational outputs, then state
  task automatic step(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [63:0] imm);
    logic [63:0] npc, res;
    logic        wr, hc, ill;
    inst = encode(op, rd, rs1, rs2, imm);
    model_exec(op, rs1, rs2, imm, npc, res, wr, hc, ill);
    #1;
    check("inst_addr", inst_addr, m_pc);
    if (m_halt)   check("dnpc_halted", dnpc, m_pc);
    else if (!hc) check("dnpc", dnpc, npc);
    if (!m_halt) begin
      if (hc) begin
        m_halt = 1'b1;
        m_trap = ill;
      end else begin
        m_pc = npc;
        if (wr && rd != 5'd0) m_x[rd] = res;
      end
    end
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    check("pc", pc, exp_q.pop_front());
    check("halt", {63'd0, halt}, {63'd0, m_halt});
    check("trap", {63'd0, trap}, {63'd0, m_trap});
    check("a0", a0, m_x[10]);
  endtask

  // copy xN into a0 so the register becomes visible
  task automatic peek(input logic [4:0] n);
    step(T_ADDI, 5'd10, n, 5'd0, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst = encode(T_ADDI, 5'd1, 5'd0, 5'd0, 64'd5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
    m_pc = RST_PC;
    m_halt = 1'b0;
    m_trap = 1'b0;
    check("reset_pc", pc, RST_PC);
    check("reset_halt", {63'd0, halt}, 64'd0);
    check("reset_trap", {63'd0, trap}, 64'd0);
    check("reset_a0", a0, 64'd0);
  endtask

  function automatic logic [63:0] rand_imm(input op_e op);
    logic [11:0] vi;
    logic [12:0] vb;
    logic [20:0] vj;
    logic [19:0] vu;
    vi = 12'($urandom_range(0, 4095));
    vb = 13'($urandom_range(0, 8191)) & 13'h1FFE;
    vj = 21'($urandom) & 21'h1FFFFE;
    vu = 20'($urandom);
    case (op)
      T_LUI, T_AUIPC:              return {44'd0, vu};
      T_JAL:                       return {{43{vj[20]}}, vj};
      T_BEQ, T_BNE, T_BLT, T_BGE,
      T_BLTU, T_BGEU:              return {{51{vb[12]}}, vb};
      T_SLLI, T_SRLI, T_SRAI:      return 64'($urandom_range(0, 63));
      default:                     return {{52{vi[11]}}, vi};
    endcase
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [63:0] r_save;
  logic [31:0] ill_words [7];

  initial begin
    ill_words = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1073, 32'h0200_0533,
                  32'h0405_5513, 32'h0000_2063, 32'h0000_151B};

    // reset and first instruction
    do_reset();
    step(T_ADDI, 5'd1, 5'd0, 5'd0, 64'd5);
    check("first_pc", pc, 64'h8000_0004);
    peek(5'd1);
    check("x1_is_5", a0, 64'd5);

    // ALU and x0
    step(T_ADDI, 5'd2, 5'd0, 5'd0, -64'sd1);
    step(T_SRLI, 5'd3, 5'd2, 5'd0, 64'd60);
    step(T_ADDW, 5'd4, 5'd2, 5'd2, 64'd0);
    step(T_ADDI, 5'd0, 5'd0, 5'd0, 64'd7);
    peek(5'd3);
    check("srli_x3", a0, 64'hF);
    peek(5'd4);
    check("addw_x4", a0, 64'hFFFF_FFFF_FFFF_FFFE);
    peek(5'd0);
    check("x0_zero", a0, 64'd0);

    // jumps
    do_reset();
    step(T_JAL, 5'd1, 5'd0, 5'd0, 64'd16);
    check("jal_pc", pc, 64'h8000_0010);
    step(T_JALR, 5'd5, 5'd1, 5'd0, 64'd3);
    check("jalr_pc", pc, 64'h8000_0006);
    peek(5'd1);
    check("jal_link", a0, 64'h8000_0004);
    peek(5'd5);
    check("jalr_link", a0, 64'h8000_0014);
    step(T_ADDI, 5'd6, 5'd0, 5'd0, 64'd40);
    step(T_JALR, 5'd6, 5'd6, 5'd0, 64'd0);
    check("jalr_rd_eq_rs1_pc", pc, 64'd40);

    // branches
    step(T_ADDI, 5'd1, 5'd0, 5'd0, -64'sd1);
    step(T_ADDI, 5'd2, 5'd0, 5'd0, 64'd1);
    r_save = pc;
    step(T_BLT, 5'd0, 5'd1, 5'd2, 64'd8);
    check("blt_taken", pc, r_save + 64'd8);
    r_save = pc;
    step(T_BLTU, 5'd0, 5'd1, 5'd2, 64'd8);
    check("bltu_not_taken", pc, r_save + 64'd4);

    // random instruction stream against the model
    for (int n = 0; n < 400; n++) begin
      op_e op;
      op = op_e'($urandom_range(0, int'(T_SUBW)));
      step(op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
           5'($urandom_range(0, 15)), rand_imm(op));
      if (n % 8 == 7) peek(5'($urandom_range(0, 15)));
    end
    for (int r = 0; r < 16; r++) peek(5'(r));

    // ebreak halt, then frozen for 5 cycles, then reset recovers
    step(T_ADDI, 5'd10, 5'd0, 5'd0, 64'd0);
    r_save = pc;
    step(T_EBREAK, 5'd0, 5'd0, 5'd0, 64'd0);
    check("ebreak_halt", {63'd0, halt}, 64'd1);
    check("ebreak_trap", {63'd0, trap}, 64'd0);
    check("ebreak_a0", a0, 64'd0);
    for (int n = 0; n < 5; n++) begin
      op_e op;
      op = op_e'($urandom_range(0, int'(T_SUBW)));
      step(op, 5'd10, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), rand_imm(op));
      check("halted_pc_hold", pc, r_save);
    end
    do_reset();

    // illegal encodings: each halts with trap and leaves a0 untouched
    foreach (ill_words[k]) begin
      step(T_ADDI, 5'd10, 5'd0, 5'd0, 64'd123);
      r_save = pc;
      step(T_ILL, 5'd0, 5'd0, 5'd0, {32'd0, ill_words[k]});
      check("illegal_trap", {63'd0, trap}, 64'd1);
      check("illegal_a0", a0, 64'd123);
      step(T_ADDI, 5'd10, 5'd0, 5'd0, 64'd7);
      check("illegal_pc_hold", pc, r_save);
      do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
